// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Bit counter must hold 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// With SERIAL_SUB_OVF_EN defined the bus also carries the signed overflow flag V.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             V;

  modport master (output start, A, B, input busy, done, D, Bout, V);
  modport slave (input start, A, B, output busy, done, D, Bout, V);
`else
  modport master (output start, A, B, input busy, done, D, Bout);
  modport slave (input start, A, B, output busy, done, D, Bout);
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor D = A - B with one full-subtractor cell and a borrow FF.
// Optional macro SERIAL_SUB_OVF_EN adds the registered signed-overflow output V.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : gen_bad_width
    $error("serial_subtractor: WIDTH must be in 2..32");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic [WIDTH-2:0] work_q;
  logic [WIDTH-1:0] work_next;
  logic [CntW-1:0]  cnt_q;
  logic             borrow_q, bout_q;
  logic             cell_d, cell_b;
  logic             accept, shift_en, last, busy, done;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_b)
  );

  assign last      = (cnt_q == CntW'(WIDTH - 1));
  // New bit enters from the MSB side; the full word is complete on the last shift.
  assign work_next = {cell_d, work_q};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StShift;
      StShift: if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    accept   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle:  accept = bus.start;
      StShift: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: D/Bout only change on the final shift, so no partial result leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.A;
      b_q      <= bus.B;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
    end else if (shift_en) begin
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      work_q   <= work_next[WIDTH-1:1];
      cnt_q    <= cnt_q + 1'b1;
      borrow_q <= cell_b;
      if (last) begin
        d_q    <= work_next;
        bout_q <= cell_b;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic v_q;

  // On the last shift the operand LSBs hold the original sign bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else if (shift_en && last) begin
      v_q <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ cell_d);
    end
  end

  assign bus.V = v_q;
`endif

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed, held-start, mid-op reset and random ops.
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic ca, cb, cbin, cd, cbo;
  full_subtractor u_cell_tb (
    .a    (ca),
    .b    (cb),
    .bin  (cbin),
    .d    (cd),
    .bout (cbo)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] last_d  = '0;
  logic         last_bo = 1'b0;

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned r;
    r = (int'(a) + 256 - int'(b)) % 256;
    return r[W-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    int r;
    r = int'($signed(a)) - int'($signed(b));
    return (r > 127) || (r < -128);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_bo, input logic exp_v);
    int  lat, bcnt;
    logic held_bad;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    bcnt = 0;
    held_bad = 1'b0;
    while (!bus.done && lat <= 2 * W + 4) begin
      if (bus.busy) bcnt++;
      if (bus.D !== last_d || bus.Bout !== last_bo) held_bad = 1'b1;
      bus.A = W'($urandom);
      bus.B = W'($urandom);
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (!bus.done) begin
      n_fail++;
      $display("FAIL op_timeout a=%h b=%h: no done within %0d cycles", a, b, lat);
      return;
    end
    n_tests++;
    if (lat != W) begin
      n_fail++;
      $display("FAIL latency a=%h b=%h: got %0d required %0d", a, b, lat, W);
    end
    n_tests++;
    if (bcnt + int'(bus.busy) != W + 1) begin
      n_fail++;
      $display("FAIL busy_cycles a=%h b=%h: got %0d required %0d", a, b,
               bcnt + int'(bus.busy), W + 1);
    end
    n_tests++;
    if (held_bad) begin
      n_fail++;
      $display("FAIL result_held a=%h b=%h: D/Bout changed mid-op, required %h/%b", a, b,
               last_d, last_bo);
    end
    n_tests++;
    if (bus.D !== exp_d || bus.Bout !== exp_bo) begin
      n_fail++;
      $display("FAIL result a=%h b=%h: got D=%h Bout=%b required D=%h Bout=%b", a, b,
               bus.D, bus.Bout, exp_d, exp_bo);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_tests++;
    if (bus.V !== exp_v) begin
      n_fail++;
      $display("FAIL overflow a=%h b=%h: got V=%b required %b", a, b, bus.V, exp_v);
    end
`endif
    last_d  = exp_d;
    last_bo = exp_bo;
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.D !== exp_d) begin
      n_fail++;
      $display("FAIL done_pulse a=%h b=%h: got done=%b busy=%b D=%h required 0 0 %h", a, b,
               bus.done, bus.busy, bus.D, exp_d);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #3;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.D !== '0 || bus.Bout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b D=%h Bout=%b required all 0",
               bus.busy, bus.done, bus.D, bus.Bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_tests++;
    if (bus.V !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_v: got %b required 0", bus.V);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cell();
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {ca, cb, cbin} = v;
      #1;
      n_tests++;
      if (cd !== (ca ^ cb ^ cbin) ||
          cbo !== ((int'(ca) - int'(cb) - int'(cbin)) < 0)) begin
        n_fail++;
        $display("FAIL cell a=%b b=%b bin=%b: got d=%b bout=%b", ca, cb, cbin, cd, cbo);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [8] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h7F};
    logic [W-1:0] tb [8] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h01, 8'h00, 8'hFF, 8'hFF};
    logic [W-1:0] td [8] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h7E, 8'h00, 8'h00, 8'h80};
    logic         tbo [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         tv [8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) run_op(ta[i], tb[i], td[i], tbo[i], tv[i]);
  endtask

  task automatic test_start_held();
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'h05;
    bus.B     = 8'h03;
    lat = 0;
    do begin
      @(negedge clk);
      bus.A = W'($urandom);
      bus.B = W'($urandom);
      lat++;
    end while (!bus.done && lat <= 2 * W + 4);
    n_tests++;
    if (!bus.done || bus.D !== 8'h02 || bus.Bout !== 1'b0) begin
      n_fail++;
      $display("FAIL held_first: got done=%b D=%h Bout=%b required 1 02 0", bus.done, bus.D,
               bus.Bout);
    end
    bus.A = 8'h10;
    bus.B = 8'h01;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat <= 2 * W + 4);
    bus.start = 1'b0;
    n_tests++;
    if (lat != W + 2) begin
      n_fail++;
      $display("FAIL back_to_back: done spacing got %0d required %0d", lat, W + 2);
    end
    n_tests++;
    if (bus.D !== 8'h0F || bus.Bout !== 1'b0) begin
      n_fail++;
      $display("FAIL held_second: got D=%h Bout=%b required 0F 0", bus.D, bus.Bout);
    end
    last_d  = 8'h0F;
    last_bo = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_idle: got busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'hC3;
    bus.B     = 8'h1E;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.D !== '0 || bus.Bout !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b done=%b D=%h Bout=%b required all 0",
               bus.busy, bus.done, bus.D, bus.Bout);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    last_d  = '0;
    last_bo = 1'b0;
    run_op(8'hAA, 8'h55, 8'h55, 1'b0, ref_ovf(8'hAA, 8'h55));
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 1200; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 10 == 0) b = a;
      if (i % 10 == 1) a = '0;
      run_op(a, b, ref_diff(a, b), a < b, ref_ovf(a, b));
    end
  endtask

  initial begin
    test_reset();
    test_cell();
    test_directed();
    test_start_held();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
